// File: rtl/nregister_rr_arbiter_pkg.sv
// Shared types, constants and the round-robin pick helper for the
// nregister_rr_arbiter block.
package nreg_pkg;

  localparam logic ARB    = 1'b0;
  localparam logic LOCKED = 1'b1;

  localparam int unsigned WR_CNT_W = 16;

  // Widest requester vector rr_pick is built for; callers zero-extend.
  localparam int unsigned MAX_REQ = 8;

  typedef enum logic {
    StArb    = ARB,
    StLocked = LOCKED
  } state_e;

  // First set bit of valid at or above ptr, wrapping modulo n.
  // Returns 0 when no bit is set.
  function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] valid,
                                         input logic [2:0]         ptr,
                                         input int unsigned        n);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      idx = (32'(ptr) + k) % n;
      if (!found && (k < n) && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/nregister_rr_arbiter_if.sv
// Requester-side bus of the shared-register arbiter: per-requester
// valid/data/lock in, one-hot ready and register status out.
interface nregister_rr_arbiter_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned N_REQ = 4
);
  localparam int unsigned IDW = $clog2(N_REQ);

  logic [N_REQ-1:0]       io_valid;
  logic [N_REQ*WIDTH-1:0] io_data;
  logic [N_REQ-1:0]       io_lock;
  logic [N_REQ-1:0]       io_ready;
  logic [IDW-1:0]         io_grant_id;
  logic [WIDTH-1:0]       io_Q;
  logic [15:0]            io_wr_count;

  modport master (
    output io_valid,
    output io_data,
    output io_lock,
    input  io_ready,
    input  io_grant_id,
    input  io_Q,
    input  io_wr_count
  );

  modport slave (
    input  io_valid,
    input  io_data,
    input  io_lock,
    output io_ready,
    output io_grant_id,
    output io_Q,
    output io_wr_count
  );

endinterface

// File: rtl/nregister_rr_arbiter_store.sv
// The shared WIDTH-bit storage register: loads d_i when en_i is high,
// cleared asynchronously by rst_ni.
module nreg_store #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] q_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_q <= '0;
    end else if (en_i) begin
      q_q <= d_i;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/nregister_rr_arbiter.sv
// Round-robin arbiter with short bus lock in front of one shared enabled
// register; also keeps a saturating count of accepted writes.
module nregister_rr_arbiter
  import nreg_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_LOCK = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  nregister_rr_arbiter_if.slave bus
);

  localparam int unsigned IDW = $clog2(N_REQ);
  localparam int unsigned LCW = $clog2(MAX_LOCK + 1);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      owner_q, owner_d;
  logic [LCW-1:0]      lock_cnt_q, lock_cnt_d;
  logic [IDW-1:0]      grant_id_q;
  logic [WR_CNT_W-1:0] wr_count_q;

  logic [IDW-1:0]   arb_pick;
  logic [IDW-1:0]   grant;
  logic [N_REQ-1:0] ready;
  logic             xfer;
  logic             grant_lock;
  logic [WIDTH-1:0] wr_data;

  function automatic logic [IDW-1:0] next_idx(input logic [IDW-1:0] x);
    return (32'(x) == N_REQ - 1) ? '0 : x + IDW'(1);
  endfunction

  assign arb_pick = IDW'(rr_pick(MAX_REQ'(bus.io_valid), 3'(ptr_q), N_REQ));

  // With no valid request arb_pick is 0 and valid[0] is 0, so ready stays 0.
  always_comb begin
    grant = arb_pick;
    ready = '0;
    if (state_q == StLocked) begin
      grant = owner_q;
    end
    ready[grant] = bus.io_valid[grant] & reset_n;
  end

  assign xfer       = |ready;
  assign grant_lock = bus.io_lock[grant];
  assign wr_data    = bus.io_data[grant*WIDTH +: WIDTH];

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    unique case (state_q)
      StArb: begin
        if (xfer) begin
          if (grant_lock && (MAX_LOCK > 1)) begin
            state_d    = StLocked;
            owner_d    = grant;
            lock_cnt_d = LCW'(1);
          end else begin
            ptr_d = next_idx(grant);
          end
        end
      end
      StLocked: begin
        if (xfer && grant_lock && (32'(lock_cnt_q) < MAX_LOCK - 1)) begin
          lock_cnt_d = lock_cnt_q + LCW'(1);
        end else begin
          // Released by the owner, by the lock limit, or by an idle cycle.
          state_d    = StArb;
          ptr_d      = next_idx(owner_q);
          lock_cnt_d = '0;
        end
      end
      default: begin
        state_d = StArb;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StArb;
      ptr_q      <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      grant_id_q <= '0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      if (xfer) begin
        grant_id_q <= grant;
        if (wr_count_q != {WR_CNT_W{1'b1}}) begin
          wr_count_q <= wr_count_q + WR_CNT_W'(1);
        end
      end
    end
  end

  nreg_store #(
    .WIDTH (WIDTH)
  ) u_store (
    .clk_i  (clk),
    .rst_ni (reset_n),
    .d_i    (wr_data),
    .en_i   (xfer),
    .q_o    (bus.io_Q)
  );

  assign bus.io_ready    = ready;
  assign bus.io_grant_id = xfer ? grant : grant_id_q;
  assign bus.io_wr_count = wr_count_q;

endmodule

// File: tb/tb_nregister_rr_arbiter.sv
// Directed plus randomized bench for nregister_rr_arbiter, checked against a
// tenure-based reference model of the arbitration rules.
module tb_nregister_rr_arbiter;

  localparam int unsigned WIDTH    = 8;
  localparam int unsigned N_REQ    = 4;
  localparam int unsigned MAX_LOCK = 4;

  logic clk;
  logic reset_n;

  nregister_rr_arbiter_if #(.WIDTH(WIDTH), .N_REQ(N_REQ)) bus ();

  nregister_rr_arbiter #(
    .WIDTH    (WIDTH),
    .N_REQ    (N_REQ),
    .MAX_LOCK (MAX_LOCK)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests;
  int failed;

  // Reference model: a tenure is one owner's run of writes under lock.
  int m_ptr;
  int m_owner;
  int m_writes;
  int m_gid;
  int m_q;
  int m_cnt;

  task automatic model_reset();
    m_ptr    = 0;
    m_owner  = -1;
    m_writes = 0;
    m_gid    = 0;
    m_q      = 0;
    m_cnt    = 0;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp)
    else begin
      failed++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are already driven; compare just before the edge, then advance the model.
  task automatic step(input bit chk, input int dir_gid);
    int   g;
    bit   x;
    int   idx;
    logic [31:0] exp_rdy;
    #2;
    g = 0;
    x = 1'b0;
    if (m_owner >= 0) begin
      g = m_owner;
      x = bus.io_valid[g];
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        idx = (m_ptr + k) % N_REQ;
        if (!x && bus.io_valid[idx]) begin
          g = idx;
          x = 1'b1;
        end
      end
    end
    exp_rdy = x ? (32'd1 << g) : 32'd0;
    if (chk) begin
      check("ready", 32'(bus.io_ready), exp_rdy);
      check("grant_id", 32'(bus.io_grant_id), x ? g : m_gid);
      check("Q", 32'(bus.io_Q), m_q);
      check("wr_count", 32'(bus.io_wr_count), m_cnt);
    end
    if (dir_gid >= 0) check("dir_grant_id", 32'(bus.io_grant_id), dir_gid);
    @(posedge clk);
    if (x) begin
      m_q   = bus.io_data[g*WIDTH +: WIDTH];
      m_gid = g;
      if (m_cnt < 65535) m_cnt++;
      m_writes = (m_owner >= 0) ? m_writes + 1 : 1;
      if (bus.io_lock[g] && m_writes < MAX_LOCK) begin
        m_owner = g;
      end else begin
        m_owner = -1;
        m_ptr   = (g + 1) % N_REQ;
      end
    end else if (m_owner >= 0) begin
      m_ptr   = (m_owner + 1) % N_REQ;
      m_owner = -1;
    end
    #1;
  endtask

  initial begin
    int exp_rr[5];
    int exp_lk[6];
    tests  = 0;
    failed = 0;
    exp_rr = '{0, 1, 2, 3, 0};
    exp_lk = '{1, 1, 1, 1, 2, 3};
    model_reset();

    // Reset with every requester asking.
    reset_n      = 1'b0;
    bus.io_valid = 4'hF;
    bus.io_lock  = 4'h0;
    bus.io_data  = {8'h43, 8'h32, 8'h21, 8'h10};
    #3;
    check("rst_ready", 32'(bus.io_ready), 0);
    check("rst_Q", 32'(bus.io_Q), 0);
    check("rst_wr_count", 32'(bus.io_wr_count), 0);
    check("rst_grant_id", 32'(bus.io_grant_id), 0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;

    // Plain round robin across all four.
    for (int i = 0; i < 5; i++) step(1'b1, exp_rr[i]);
    check("rr_Q", 32'(bus.io_Q), 32'h10);
    check("rr_count", 32'(bus.io_wr_count), 5);

    // Requester 1 holds the bus for MAX_LOCK writes, then the grant moves on.
    bus.io_lock = 4'b0010;
    for (int i = 0; i < 6; i++) step(1'b1, exp_lk[i]);

    // Requester 2 locks once then goes idle; the idle cycle writes nothing.
    bus.io_valid = 4'b0100;
    bus.io_lock  = 4'b0100;
    step(1'b1, 2);
    bus.io_valid = 4'b1000;
    bus.io_lock  = 4'b0000;
    step(1'b1, 2);
    check("idle_Q", 32'(bus.io_Q), 32'h32);
    step(1'b1, 3);

    // Asynchronous reset while requester 0 owns the lock.
    bus.io_valid = 4'b0001;
    bus.io_lock  = 4'b0001;
    step(1'b1, 0);
    #3;
    reset_n = 1'b0;
    #1;
    check("midrst_Q", 32'(bus.io_Q), 0);
    check("midrst_ready", 32'(bus.io_ready), 0);
    check("midrst_count", 32'(bus.io_wr_count), 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    bus.io_valid = 4'hF;
    bus.io_lock  = 4'h0;
    step(1'b1, 0);
    step(1'b1, 1);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      bus.io_valid = 4'($urandom_range(0, 15));
      bus.io_lock  = 4'($urandom_range(0, 15));
      bus.io_data  = $urandom;
      step(1'b1, -1);
    end

    // Counter saturation.
    reset_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    #1;
    reset_n      = 1'b1;
    bus.io_valid = 4'hF;
    bus.io_lock  = 4'h0;
    for (int i = 0; i < 65537; i++) step(1'b0, -1);
    check("sat_count", 32'(bus.io_wr_count), 32'hFFFF);
    for (int i = 0; i < 3; i++) step(1'b1, -1);
    check("sat_hold", 32'(bus.io_wr_count), 32'hFFFF);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/nregister_rr_arbiter.md
Name: nregister_rr_arbiter

Overview:
- Shares one WIDTH-bit enabled storage register among N_REQ requesters using round-robin arbitration with a valid/ready handshake.
- Supports a short bus lock so that one requester can issue back-to-back writes without interleaving from others.
- Sits in front of the enabled-register datapath: it generates that register's D/enable and exposes its Q.
- Also keeps a saturating count of accepted writes for debug.

Parameters:
- WIDTH, 8, data width of the shared register.
- N_REQ, 4, number of requesters (2..8).
- MAX_LOCK, 4, maximum consecutive writes one owner may make under lock (>=1).
- IDW, $clog2(N_REQ), grant-id width (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  asynchronous, active-low reset.
- io_valid  in  N_REQ  per-requester write request.
- io_data  in  N_REQ*WIDTH  write data; requester i occupies bits [i*WIDTH +: WIDTH].
- io_lock  in  N_REQ  requester i asks to keep ownership after its current write.
- io_ready  out  N_REQ  one-hot (or zero); write accepted on valid[i]&ready[i].
- io_grant_id  out  IDW  index of the current grantee; holds its last value when nothing is granted.
- io_Q  out  WIDTH  shared register contents.
- io_wr_count  out  16  accepted-write counter, saturates at 16'hFFFF.

Behaviour:
Reset (async, reset_n=0):
- io_Q=0, rr pointer=0, state=ARB, lock count=0, owner=0, io_grant_id=0, io_wr_count=0.
- io_ready=0 while reset_n=0.

State ARB:
- Grant is combinational: the first i with io_valid[i]=1, searching from the rr pointer upward and wrapping modulo N_REQ.
- io_ready[grant]=1 and io_grant_id=grant; no valid means io_ready=0.
- On a transfer with io_lock[grant]=0: pointer <= grant+1 (mod N_REQ).
- On a transfer with io_lock[grant]=1: state <= LOCKED, owner <= grant, lock count <= 1. The pointer does not move.
- Special case MAX_LOCK=1: a locked transfer behaves as unlocked.

State LOCKED:
- Only the owner is eligible. io_ready[owner]=io_valid[owner]; all other ready bits are 0.
- Owner transfer with io_lock=1 and lock count < MAX_LOCK-1: stay in LOCKED, count++.
- Owner transfer with io_lock=0, or with count == MAX_LOCK-1 (forced release; this final write is still accepted): state <= ARB, pointer <= owner+1.
- Owner valid=0 for one cycle: state <= ARB, pointer <= owner+1, no write. Idle-cycle release prevents starvation.

Datapath:
- On any transfer, io_Q <= granted data at the next rising edge (latency 1 from handshake to io_Q).
- With no transfer, io_Q holds.

Counter:
- io_wr_count increments by 1 per transfer and holds at 16'hFFFF.

Other rules:
- At most one transfer per cycle.
- Simultaneous requests are resolved by the pointer only; no fixed priority.
- Changes to io_data or io_lock of a non-granted requester have no effect.
- Reset asserted mid-lock returns to ARB immediately; no partial state survives.

Decomposition:
- Shared package nreg_pkg holds:
  - localparams for the state encoding (ARB=1'b0, LOCKED=1'b1);
  - the WR_CNT_W=16 constant;
  - a function rr_pick(valid, ptr) returning the round-robin index.
- One natural sub-module, nreg_store: a WIDTH-bit register with enable and async active-low clear. It is fed D/enable by the arbiter and outputs Q.

Test Plan:
1. Reset: hold reset_n=0 with all valid=1 -> io_ready=0, io_Q=0, io_wr_count=0. Release reset -> first grant goes to requester 0.
2. Round robin: all four valid, data=8'h10,8'h21,8'h32,8'h43, lock=0, for 5 cycles -> grants 0,1,2,3,0. io_Q one cycle later reads 10,21,32,43,10. io_wr_count=5.
3. Lock burst: req1 valid+lock for 6 cycles, others valid, MAX_LOCK=4 -> req1 gets 4 consecutive grants, then the grant moves to 2. Count=4 accepted from req1.
4. Idle release: req2 locks once, then drops valid for 1 cycle while req3 is valid -> the idle cycle has no write. Next cycle grants 3. io_Q is unchanged during the idle cycle.
5. Reset mid-lock: assert reset_n=0 asynchronously during LOCKED (between clock edges) -> io_Q=0 immediately. After release, state=ARB and pointer=0.
6. Saturation: force 65537 transfers -> io_wr_count=16'hFFFF and stays there.
